// File: rtl/label_resolver.sv
// label_resolver: resolves a connected-component equivalence table at end of
// frame. Flatten each entry to its root, then stream (label, root) records
// through a valid/ready handshake.
// Optional feature macro: LABEL_COMPACT_EN -- adds the cid RAM so that
// out_root carries a dense 1..num_objects ID instead of the root label.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module label_resolver #(
  parameter int W = `WORD_SIZE
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         wen,
  input  logic [W-1:0] w_addr,
  input  logic [W-1:0] data_in,
  input  logic [W-1:0] num_labels,
  input  logic         frame_end,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_label,
  output logic [W-1:0] out_root,
  output logic [W-1:0] num_objects,
  output logic         busy,
  output logic         done
);

  localparam int DEPTH = 2 ** W;

  typedef enum logic [2:0] {
    COLLECT, FL_RD, FL_PAR, FL_WR, EM_RD, EM_OUT, DONE
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] i_q, i_d;
  logic [W-1:0] n_q, n_d;
  logic [W-1:0] p_q, p_d;
  logic [W-1:0] num_objects_q, num_objects_d;

  // Equivalence table: one write port, one synchronous read port.
  logic [W-1:0] tbl_mem [DEPTH];
  logic [W-1:0] tbl_rd_q;
  logic         tbl_we, tbl_re;
  logic [W-1:0] tbl_waddr, tbl_wdata, tbl_raddr;

  // An entry whose parent is itself or a later label is a root of its own.
  logic         is_root;
  logic [W-1:0] root_val;
  logic [W-1:0] root_out;
  logic         last_idx;

  assign is_root  = (p_q >= i_q);
  assign root_val = is_root ? i_q : tbl_rd_q;
  assign last_idx = (i_q == n_q - W'(1));

  // State and counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q       <= COLLECT;
      i_q           <= '0;
      n_q           <= '0;
      p_q           <= '0;
      num_objects_q <= '0;
    end else if (en) begin
      state_q       <= state_d;
      i_q           <= i_d;
      n_q           <= n_d;
      p_q           <= p_d;
      num_objects_q <= num_objects_d;
    end
  end

  // Next-state, counter updates and table port control.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    i_d           = i_q;
    n_d           = n_q;
    p_d           = p_q;
    num_objects_d = num_objects_q;
    tbl_we        = 1'b0;
    tbl_waddr     = w_addr;
    tbl_wdata     = data_in;
    tbl_re        = 1'b0;
    tbl_raddr     = i_q;
    if (en) begin
      unique case (state_q)
        COLLECT: begin
          tbl_we = wen;
          if (frame_end) begin
            n_d           = num_labels;
            i_d           = W'(1);
            num_objects_d = '0;
            state_d       = (num_labels <= W'(1)) ? DONE : FL_RD;
          end
        end
        FL_RD: begin
          tbl_re  = 1'b1;
          state_d = FL_PAR;
        end
        FL_PAR: begin
          p_d       = tbl_rd_q;
          tbl_re    = 1'b1;
          tbl_raddr = tbl_rd_q;
          state_d   = FL_WR;
        end
        FL_WR: begin
          tbl_we    = 1'b1;
          tbl_waddr = i_q;
          tbl_wdata = root_val;
          if (is_root) num_objects_d = num_objects_q + W'(1);
          if (last_idx) begin
            i_d     = W'(1);
            state_d = EM_RD;
          end else begin
            i_d     = i_q + W'(1);
            state_d = FL_RD;
          end
        end
        EM_RD: begin
          tbl_re  = 1'b1;
          state_d = EM_OUT;
        end
        EM_OUT: begin
          if (out_ready) begin
            if (last_idx) begin
              state_d = DONE;
            end else begin
              i_d     = i_q + W'(1);
              state_d = EM_RD;
            end
          end
        end
        DONE:    state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  // Table RAM: synchronous write and registered read.
  always_ff @(posedge clk) begin
    // NOTE: RAM contents and its read register carry no reset; they map onto
    // block RAM, and nothing reads them before a frame rewrites them.
    if (tbl_we && reset_n) tbl_mem[tbl_waddr] <= tbl_wdata;
    if (tbl_re)            tbl_rd_q <= tbl_mem[tbl_raddr];
  end

`ifdef LABEL_COMPACT_EN
  logic [W-1:0] cid_mem [DEPTH];
  logic [W-1:0] cid_rd_q;
  logic [W-1:0] next_id_q, next_id_d;
  logic         cid_we, cid_re;
  logic [W-1:0] cid_raddr, cid_wdata;

  // Dense-ID allocation and cid RAM port control, tracking the flatten walk.
  always_comb begin
    next_id_d = next_id_q;
    cid_we    = 1'b0;
    cid_re    = 1'b0;
    cid_raddr = i_q;
    cid_wdata = cid_rd_q;
    if (en) begin
      unique case (state_q)
        COLLECT: if (frame_end) next_id_d = W'(1);
        FL_PAR: begin
          cid_re    = 1'b1;
          cid_raddr = tbl_rd_q;
        end
        FL_WR: begin
          cid_we = 1'b1;
          if (is_root) begin
            cid_wdata = next_id_q;
            next_id_d = next_id_q + W'(1);
          end
        end
        EM_RD:   cid_re = 1'b1;
        default: ;
      endcase
    end
  end

  // Next-ID counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) next_id_q <= W'(1);
    else          next_id_q <= next_id_d;
  end

  // cid RAM: synchronous write and registered read.
  always_ff @(posedge clk) begin
    if (cid_we && reset_n) cid_mem[i_q] <= cid_wdata;
    if (cid_re)            cid_rd_q <= cid_mem[cid_raddr];
  end

  assign root_out = cid_rd_q;
`else
  assign root_out = tbl_rd_q;
`endif

  // Outputs decoded from state; record fields read zero outside EM_OUT.
  always_comb begin
    busy        = (state_q != COLLECT);
    done        = (state_q == DONE);
    out_valid   = (state_q == EM_OUT);
    out_label   = out_valid ? i_q : '0;
    out_root    = out_valid ? root_out : '0;
    num_objects = num_objects_q;
  end

endmodule

// File: tb/tb_label_resolver.sv
// Self-checking bench for label_resolver: directed scenarios plus randomized
// frames, compared against a behavioural flatten/compact model.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module tb_label_resolver;

  localparam int W     = `WORD_SIZE;
  localparam int DEPTH = 2 ** W;

  localparam int M_NONE  = 0;
  localparam int M_BP    = 1;  // hold out_ready low 5 cycles on record 2
  localparam int M_RAND  = 2;  // random out_ready
  localparam int M_STALL = 3;  // en low 3 cycles mid-flatten
  localparam int M_FE    = 4;  // spurious frame_end while busy

  logic         clk = 1'b0;
  logic         reset_n, en, wen, frame_end, out_ready;
  logic [W-1:0] w_addr, data_in, num_labels;
  logic         out_valid, busy, done;
  logic [W-1:0] out_label, out_root, num_objects;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] tbl_m [DEPTH];
  int           exp_root [$];
  int           exp_obj;

  label_resolver #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .wen(wen), .w_addr(w_addr),
    .data_in(data_in), .num_labels(num_labels), .frame_end(frame_end),
    .out_valid(out_valid), .out_ready(out_ready), .out_label(out_label),
    .out_root(out_root), .num_objects(num_objects), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: each entry points to a parent; a parent at or above the entry
  // starts a new object, otherwise the entry joins its parent's object.
  function automatic void build_model(input int n);
    int root [DEPTH];
    int cid  [DEPTH];
    exp_root.delete();
    exp_obj = 0;
    for (int i = 1; i < n; i++) begin
      int p;
      p = int'(tbl_m[i]);
      if (p >= i) begin
        exp_obj++;
        root[i] = i;
        cid[i]  = exp_obj;
      end else begin
        root[i] = root[p];
        cid[i]  = cid[p];
      end
`ifdef LABEL_COMPACT_EN
      exp_root.push_back(cid[i]);
`else
      exp_root.push_back(root[i]);
`endif
    end
    for (int i = 1; i < n; i++) tbl_m[i] = W'(root[i]);
  endfunction

  task automatic wr(input int a, input int d);
    wen = 1'b1; w_addr = W'(a); data_in = W'(d);
    tbl_m[a] = W'(d);
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic run_frame(input int n, input int mode, input string name);
    int  rec, done_cnt, first_valid, bp_left;
    bit  have_prev, finished;
    logic [W-1:0] prev_label, prev_root;
    rec = 0; done_cnt = 0; first_valid = -1; bp_left = 5;
    have_prev = 0; finished = 0; prev_label = '0; prev_root = '0;
    frame_end = 1'b1; num_labels = W'(n);
    @(negedge clk);
    frame_end = 1'b0;
    build_model(n);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (done_cnt > 0 && !done) begin
        finished = 1;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_after_done: got %b want 0", name, busy);
        else passed++;
      end else begin
        if (done) done_cnt++;
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && have_prev) begin
          checks++;
          if ({out_label, out_root} !== {prev_label, prev_root})
            $display("FAIL %s hold_stable: got (%0d,%0d) want (%0d,%0d)",
                     name, out_label, out_root, prev_label, prev_root);
          else passed++;
        end
        out_ready = 1'b1;
        if (mode == M_BP && out_valid && rec == 1 && bp_left > 0) begin
          out_ready = 1'b0; bp_left--;
        end else if (mode == M_RAND) begin
          out_ready = ($urandom_range(0, 2) != 0);
        end
        en        = !(mode == M_STALL && cyc >= 4 && cyc < 7);
        frame_end = (mode == M_FE && cyc == 2);
        if (mode == M_FE && cyc == 2) num_labels = W'(2);
        if (out_valid && out_ready && en) begin
          checks++;
          if (rec >= exp_root.size())
            $display("FAIL %s extra_record: got (%0d,%0d) want none", name, out_label, out_root);
          else if ({out_label, out_root} !== {W'(rec + 1), W'(exp_root[rec])})
            $display("FAIL %s record%0d: got (%0d,%0d) want (%0d,%0d)",
                     name, rec, out_label, out_root, rec + 1, exp_root[rec]);
          else passed++;
          rec++;
          have_prev = 0;
        end else begin
          have_prev  = out_valid;
          prev_label = out_label;
          prev_root  = out_root;
        end
        @(negedge clk);
        frame_end = 1'b0;
      end
    end
    en = 1'b1; out_ready = 1'b1;
    checks++;
    if (!finished) $display("FAIL %s timeout: got no done within budget want done", name);
    else passed++;
    checks++;
    if (rec !== exp_root.size()) $display("FAIL %s record_count: got %0d want %0d", name, rec, exp_root.size());
    else passed++;
    checks++;
    if (num_objects !== W'(exp_obj)) $display("FAIL %s num_objects: got %0d want %0d", name, num_objects, exp_obj);
    else passed++;
    checks++;
    if (done_cnt !== 1) $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
    else passed++;
    if (mode == M_NONE && n >= 2) begin
      checks++;
      if (first_valid !== 3 * (n - 1) + 1)
        $display("FAIL %s first_valid_latency: got %0d want %0d", name, first_valid, 3 * (n - 1) + 1);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL reset_flags: got v=%b b=%b d=%b want 0 0 0", out_valid, busy, done);
    else passed++;
    checks++;
    if ({num_objects, out_label, out_root} !== '0)
      $display("FAIL reset_values: got obj=%0d lbl=%0d root=%0d want 0 0 0", num_objects, out_label, out_root);
    else passed++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_simple_merge();
    wr(1, 1); wr(2, 2); wr(3, 3); wr(3, 1);
    run_frame(4, M_NONE, "simple_merge");
  endtask

  task automatic test_chain();
    wr(1, 1); wr(2, 1); wr(3, 2); wr(4, 3);
    run_frame(5, M_NONE, "chain");
    wr(1, 1); wr(2, 7);
    run_frame(3, M_NONE, "invalid_parent");
  endtask

  task automatic test_backpressure();
    wr(1, 1); wr(2, 1); wr(3, 3); wr(4, 2); wr(5, 3);
    run_frame(6, M_BP, "backpressure");
  endtask

  task automatic test_boundaries();
    run_frame(1, M_NONE, "single_label");
    wr(1, 1); wr(2, 1); wr(3, 3); wr(4, 2);
    run_frame(5, M_FE, "frame_end_busy");
    wr(1, 1); wr(2, 1); wr(3, 3); wr(4, 2);
    run_frame(5, M_STALL, "en_stall");
  endtask

  task automatic test_reset_mid_emit();
    int waited, late_valid;
    wr(1, 1); wr(2, 1); wr(3, 2);
    out_ready = 1'b0;
    frame_end = 1'b1; num_labels = W'(4);
    @(negedge clk);
    frame_end = 1'b0;
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!out_valid) $display("FAIL reset_emit_reach: got out_valid=0 want 1");
    else passed++;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done, out_label, out_root, num_objects} !== '0)
      $display("FAIL reset_emit_outputs: got v=%b b=%b d=%b lbl=%0d root=%0d obj=%0d want all 0",
               out_valid, busy, done, out_label, out_root, num_objects);
    else passed++;
    reset_n = 1'b1; out_ready = 1'b1;
    late_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || busy) late_valid++;
    end
    checks++;
    if (late_valid !== 0) $display("FAIL reset_emit_abort: got %0d active cycles want 0", late_valid);
    else passed++;
  endtask

  task automatic test_compact();
    wr(1, 1); wr(2, 1); wr(3, 3); wr(4, 4); wr(4, 3);
    run_frame(5, M_NONE, "compact");
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(2, 24);
      for (int i = 1; i < n; i++) begin
        if ($urandom_range(0, 9) < 7) wr(i, $urandom_range(1, i));
        else                          wr(i, $urandom_range(i, DEPTH - 1));
      end
      run_frame(n, M_RAND, "random");
    end
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; wen = 1'b0; frame_end = 1'b0; out_ready = 1'b1;
    w_addr = '0; data_in = '0; num_labels = '0;
    @(negedge clk);
    test_reset();
    test_simple_merge();
    test_chain();
    test_backpressure();
    test_boundaries();
    test_reset_mid_emit();
    test_compact();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
